// File: rtl/sr_excite_driver_if.sv
// Target handshake, flop-bank excitation/feedback and status signals of the S/R excitation driver.
// "master" is the side that offers targets and owns the flop bank; "slave" is the driver.
interface sr_excite_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_mask;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, s, r, busy, done, err, err_mask
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, s, r, busy, done, err, err_mask
  );
endinterface

// File: rtl/sr_excite_driver.sv
// Converts target words into one-cycle S/R excitation pulses for a bank of S/R flops,
// verifies the flop outputs afterwards and re-drives stale bits a bounded number of times.
//
// state | meaning
// IDLE  | ready for a target; s=r=0; done/err pulse appears here
// DRIVE | s/r hold the excitation for one cycle; flops capture at its end
// CHECK | s=r=0; q_fb compared to the latched target
module sr_excite_driver #(
  parameter int WIDTH     = 4,
  parameter int RETRY_MAX = 2
) (
  input  logic                clk,
  input  logic                rst,
  sr_excite_driver_if.slave   bus
);

  localparam int CW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target, target_nxt;
  logic [WIDTH-1:0] s_q, s_nxt;
  logic [WIDTH-1:0] r_q, r_nxt;
  logic [WIDTH-1:0] mask_q, mask_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic [CW-1:0]    retry_q, retry_nxt;

  // Bits already at their target resolve to hold, so S and R can never both be set.
  function automatic logic [WIDTH-1:0] set_exc(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    return ~q & t;
  endfunction

  function automatic logic [WIDTH-1:0] rst_exc(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    return q & ~t;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    s_nxt      = '0;
    r_nxt      = '0;
    mask_nxt   = mask_q;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    retry_nxt  = retry_q;
    case (state)
      IDLE: begin
        if (bus.tgt_valid) begin
          target_nxt = bus.tgt_data;
          s_nxt      = set_exc(bus.q_fb, bus.tgt_data);
          r_nxt      = rst_exc(bus.q_fb, bus.tgt_data);
          mask_nxt   = '0;
          retry_nxt  = '0;
          state_nxt  = DRIVE;
        end
      end
      DRIVE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (bus.q_fb == target) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (retry_q < CW'(RETRY_MAX)) begin
          retry_nxt = retry_q + 1'b1;
          s_nxt     = set_exc(bus.q_fb, target);
          r_nxt     = rst_exc(bus.q_fb, target);
          state_nxt = DRIVE;
        end else begin
          err_nxt   = 1'b1;
          mask_nxt  = bus.q_fb ^ target;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target  <= '0;
      s_q     <= '0;
      r_q     <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      target  <= target_nxt;
      s_q     <= s_nxt;
      r_q     <= r_nxt;
      mask_q  <= mask_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      retry_q <= retry_nxt;
    end
  end

  assign bus.tgt_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_mask  = mask_q;

endmodule

// File: tb/tb_sr_excite_driver.sv
// Bench for sr_excite_driver: a flop-bank model with stuck-at injection, a transaction-level
// prediction of every output cycle, and directed scenarios with literal expectations.
module tb_sr_excite_driver;
  localparam int WIDTH     = 4;
  localparam int RETRY_MAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr_excite_driver_if #(.WIDTH(WIDTH)) bus ();

  sr_excite_driver #(.WIDTH(WIDTH), .RETRY_MAX(RETRY_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Flop bank driven by the DUT; stuck bits read back as 0.
  logic [WIDTH-1:0] q_reg = '0;
  logic [WIDTH-1:0] stuck = '0;
  assign bus.q_fb = q_reg & ~stuck;
  always @(posedge clk) q_reg <= (q_reg | bus.s) & ~bus.r;

  int n_chk  = 0;
  int n_fail = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             ready;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] mask;
  } rec_t;

  function automatic rec_t idle_rec(input logic [WIDTH-1:0] mask, input logic dn, input logic er);
    rec_t x;
    x.s = '0; x.r = '0; x.busy = 1'b0; x.ready = 1'b1;
    x.done = dn; x.err = er; x.mask = mask;
    return x;
  endfunction

  function automatic rec_t busy_rec(input logic [WIDTH-1:0] se, input logic [WIDTH-1:0] re);
    rec_t x;
    x.s = se; x.r = re; x.busy = 1'b1; x.ready = 1'b0;
    x.done = 1'b0; x.err = 1'b0; x.mask = '0;
    return x;
  endfunction

  rec_t cur;
  rec_t plan_q[$];
  initial cur = idle_rec('0, 1'b0, 1'b0);

  // Whole-transaction prediction: each attempt is one drive cycle plus one check cycle;
  // the flop bank ends at the target except for stuck bits.
  task automatic plan(input logic [WIDTH-1:0] q0, input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] qq, se, re;
    logic ok;
    qq = q0;
    ok = 1'b0;
    for (int a = 0; a <= RETRY_MAX && !ok; a++) begin
      se = ~qq & t;
      re = qq & ~t;
      plan_q.push_back(busy_rec(se, re));
      qq = ((qq | se) & ~re) & ~stuck;
      plan_q.push_back(busy_rec('0, '0));
      if (qq == t) ok = 1'b1;
    end
    if (ok) plan_q.push_back(idle_rec('0, 1'b1, 1'b0));
    else    plan_q.push_back(idle_rec(qq ^ t, 1'b0, 1'b1));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      plan_q.delete();
      cur = idle_rec('0, 1'b0, 1'b0);
    end else begin
      if (cur.ready && bus.tgt_valid) begin
        plan_q.delete();
        plan(bus.q_fb, bus.tgt_data);
      end
      if (plan_q.size() > 0) cur = plan_q.pop_front();
      else                   cur = idle_rec(cur.mask, 1'b0, 1'b0);
    end
  end

  always @(negedge clk) begin
    chk("s",         bus.s,         cur.s);
    chk("r",         bus.r,         cur.r);
    chk("busy",      bus.busy,      cur.busy);
    chk("tgt_ready", bus.tgt_ready, cur.ready);
    chk("done",      bus.done,      cur.done);
    chk("err",       bus.err,       cur.err);
    chk("err_mask",  bus.err_mask,  cur.mask);
    chk("s_and_r",   bus.s & bus.r, '0);
    chk("done_err",  bus.done & bus.err, 1'b0);
    if (bus.done) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    chk("send_ready", bus.tgt_ready, 1'b1);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = d;
    tick();
    bus.tgt_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (bus.done) got = 1'b1;
    end
    chk(name, got, 1'b1);
  endtask

  task automatic chk_idle_reset(input string name);
    chk({name, "_s"},     bus.s,         '0);
    chk({name, "_r"},     bus.r,         '0);
    chk({name, "_done"},  bus.done,      1'b0);
    chk({name, "_err"},   bus.err,       1'b0);
    chk({name, "_mask"},  bus.err_mask,  '0);
    chk({name, "_ready"}, bus.tgt_ready, 1'b1);
    chk({name, "_busy"},  bus.busy,      1'b0);
  endtask

  initial begin
    int n_drv, n_acc, d0;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    rst = 1'b0;
    repeat (3) tick();
    chk_idle_reset("por");
    rst = 1'b1;
    tick();

    // Clean set from all-zero flops.
    send(4'b1010);
    chk("t2_drive_s", bus.s, 4'b1010);
    chk("t2_drive_r", bus.r, 4'b0000);
    repeat (2) tick();
    chk("t2_done", bus.done, 1'b1);
    chk("t2_err",  bus.err,  1'b0);
    tick();

    // Mixed set/reset, no retry expected.
    chk("t3_q_start", bus.q_fb, 4'b1010);
    send(4'b0110);
    chk("t3_drive_s", bus.s, 4'b0100);
    chk("t3_drive_r", bus.r, 4'b1000);
    repeat (2) tick();
    chk("t3_done", bus.done, 1'b1);
    tick();

    // Bit 0 stuck at 0: every attempt re-drives it, then err.
    stuck = 4'b0001;
    send(4'b0001);
    n_drv = 0;
    for (int i = 0; i < 20 && !bus.err; i++) begin
      if (bus.s == 4'b0001) n_drv++;
      tick();
    end
    chk("t4_drives",   n_drv,        3);
    chk("t4_err",      bus.err,      1'b1);
    chk("t4_done",     bus.done,     1'b0);
    chk("t4_err_mask", bus.err_mask, 4'b0001);

    // Async reset in the err cycle clears everything at once and holds through release.
    #2 rst = 1'b0;
    #1 chk_idle_reset("t1_async");
    tick();
    chk_idle_reset("t1_hold");
    rst = 1'b1;
    #2 chk_idle_reset("t1_release");
    stuck = '0;
    tick();

    // Reset pulse during DRIVE: no capture, no done/err, then a normal transfer.
    chk("t6_q_start", bus.q_fb, 4'b0001);
    d0 = done_seen;
    send(4'b0101);
    chk("t6_drive_s", bus.s, 4'b0100);
    #2 rst = 1'b0;
    #1 chk_idle_reset("t6_async");
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t6_no_done", done_seen - d0, 0);
    chk("t6_q_kept",  bus.q_fb, 4'b0001);
    send(4'b0110);
    wait_done("t6_recover_timeout");
    chk("t6_q_final", bus.q_fb, 4'b0110);
    tick();

    // Continuous valid with alternating data: accepts only at IDLE, including done cycles.
    d0 = done_seen;
    n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = (i % 2 == 1) ? 4'b0011 : 4'b1100;
      if (bus.tgt_ready) n_acc++;
      tick();
    end
    bus.tgt_valid = 1'b0;
    repeat (3) tick();
    chk("t5_accepts", n_acc, 3);
    chk("t5_dones",   done_seen - d0, 3);
    chk("t5_q_final", bus.q_fb, 4'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
